clk_tick_gen: RTL and testbench

Multi-channel, runtime-programmable tick and square-wave generator; successor to the fixed two-output clock divider. Each of NUM_CH channels divides the system clock by its own divisor and produces a one-cycle enable strobe plus an optional square wave. All outputs are in the `clk` domain; no derived clocks are created. The game core uses it for the 1 Hz game tick, display scan, and a mole-rate tick whose divisor is reprogrammed as difficulty rises.

---
 rtl/clk_tick_gen_pkg.sv | 15 +
 rtl/clk_tick_gen_ch.sv | 95 +++++++++
 rtl/clk_tick_gen.sv | 52 +++++
 tb/tb_clk_tick_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
package clk_tick_gen_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int MAX_CNT_W = 64;

    // Divisors for a 100 MHz clk
    localparam logic [31:0] DIV_1HZ  = 32'd100_000_000;
    localparam logic [31:0] DIV_1KHZ = 32'd100_000;

    function automatic logic [MAX_CNT_W-1:0] half_period(input logic [MAX_CNT_W-1:0] div);
        return div >> 1;
    endfunction

endpackage

// File: rtl/clk_tick_gen_ch.sv
// One tick channel: counter, shadow divisor, pending flag, tick strobe and optional square wave.
// Square output is built only when CLK_TICK_GEN_SQUARE_EN is defined.
module clk_tick_gen_ch
    import clk_tick_gen_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_1HZ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             restart,
    output logic             pending,
    output logic             tick
`ifdef CLK_TICK_GEN_SQUARE_EN
    ,
    output logic             sq
`endif
);

    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shd;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             wrap;

    assign run  = en && (div != '0);
    assign wrap = run && (cnt == div - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= DIV_RST;
            shd     <= DIV_RST;
            cnt     <= '0;
            pending <= 1'b0;
            tick    <= 1'b0;
        end else if (restart) begin
            // Realign: a write in the same cycle wins over the queued shadow
            cnt     <= '0;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (wr) begin
                div <= wr_div;
                shd <= wr_div;
            end else if (pending) begin
                div <= shd;
            end
        end else if (!run) begin
            cnt  <= '0;
            tick <= 1'b0;
            if (wr) begin
                div     <= wr_div;
                shd     <= wr_div;
                pending <= 1'b0;
            end
        end else begin
            tick <= wrap;
            if (wrap) begin
                cnt <= '0;
                if (wr) begin
                    div     <= wr_div;
                    shd     <= wr_div;
                    pending <= 1'b0;
                end else if (pending) begin
                    div     <= shd;
                    pending <= 1'b0;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (wr) begin
                    shd     <= wr_div;
                    pending <= 1'b1;
                end
            end
        end
    end

`ifdef CLK_TICK_GEN_SQUARE_EN
    logic [CNT_W-1:0] half;

    assign half = CNT_W'(half_period(MAX_CNT_W'(div)));

    // Registered from the pre-increment count so sq lines up with the tick strobe
    always_ff @(posedge clk) begin
        if (rst || restart || !run) begin
            sq <= 1'b0;
        end else begin
            sq <= (cnt >= half);
        end
    end
`endif

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel programmable tick generator: decodes divisor writes and instantiates one channel each.
// Define CLK_TICK_GEN_SQUARE_EN to add the per-channel square-wave output sq.
module clk_tick_gen
    import clk_tick_gen_pkg::*;
#(
    parameter int                      NUM_CH   = 4,
    parameter int                      CNT_W    = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {NUM_CH{CNT_W'(DIV_1HZ)}}
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                              cfg_div,
    input  logic [NUM_CH-1:0]                             ch_en,
    input  logic                                          sync_restart,
    output logic [NUM_CH-1:0]                             cfg_pending,
    output logic [NUM_CH-1:0]                             tick
`ifdef CLK_TICK_GEN_SQUARE_EN
    ,
    output logic [NUM_CH-1:0]                             sq
`endif
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Out-of-range cfg_ch values match no channel and are dropped
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_sel;

        assign wr_sel = cfg_we && (cfg_ch == CH_W'(i));

        clk_tick_gen_ch #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[i]),
            .wr      (wr_sel),
            .wr_div  (cfg_div),
            .restart (sync_restart),
            .pending (cfg_pending[i]),
            .tick    (tick[i])
`ifdef CLK_TICK_GEN_SQUARE_EN
            ,
            .sq      (sq[i])
`endif
        );
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Self-checking bench for clk_tick_gen: directed scenarios plus randomized traffic against a cycle-stamp model.
module tb_clk_tick_gen;

    localparam int NCH = 3;
    localparam int CW  = 32;
    localparam longint INIT [NCH] = '{4, 5, 8};

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic [NCH-1:0] ch_en;
    logic           sync_restart;
    logic [NCH-1:0] cfg_pending;
    logic [NCH-1:0] tick;
`ifdef CLK_TICK_GEN_SQUARE_EN
    logic [NCH-1:0] sq;
`endif

    clk_tick_gen #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .DIV_INIT ({32'd8, 32'd5, 32'd4})
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .cfg_pending  (cfg_pending),
        .tick         (tick)
`ifdef CLK_TICK_GEN_SQUARE_EN
        ,
        .sq           (sq)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int base   = 0;

    // Model: each channel remembers the cycle its current period started; a tick is due
    // when exactly div cycles have elapsed since then.
    longint         m_div [NCH];
    longint         m_shd [NCH];
    bit             m_pend[NCH];
    int             m_s   [NCH];
    logic [NCH-1:0] e_tick;
    logic [NCH-1:0] e_sq;
    logic [NCH-1:0] e_pend;

    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            bit     wr;
            longint p;
            wr = cfg_we && (int'(cfg_ch) == i);
            if (rst) begin
                m_div[i] = INIT[i]; m_shd[i] = INIT[i]; m_pend[i] = 0;
                m_s[i] = cyc; e_tick[i] = 0; e_sq[i] = 0;
            end else if (sync_restart) begin
                m_s[i] = cyc; e_tick[i] = 0; e_sq[i] = 0;
                if (wr) begin m_div[i] = cfg_div; m_shd[i] = cfg_div; end
                else if (m_pend[i]) m_div[i] = m_shd[i];
                m_pend[i] = 0;
            end else if (!ch_en[i] || m_div[i] == 0) begin
                m_s[i] = cyc; e_tick[i] = 0; e_sq[i] = 0;
                if (wr) begin m_div[i] = cfg_div; m_shd[i] = cfg_div; m_pend[i] = 0; end
            end else begin
                p = cyc - m_s[i];
                e_tick[i] = (p == m_div[i]);
                e_sq[i]   = ((p - 1) >= (m_div[i] / 2));
                if (p == m_div[i]) begin
                    m_s[i] = cyc;
                    if (wr) begin m_div[i] = cfg_div; m_shd[i] = cfg_div; m_pend[i] = 0; end
                    else if (m_pend[i]) begin m_div[i] = m_shd[i]; m_pend[i] = 0; end
                end else if (wr) begin
                    m_shd[i] = cfg_div; m_pend[i] = 1;
                end
            end
            e_pend[i] = m_pend[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic set_wr(input bit we, input int ch, input int v);
        cfg_we  = we;
        cfg_ch  = 2'(ch);
        cfg_div = CW'(v);
    endtask

    task automatic do_reset(input logic [NCH-1:0] en);
        rst = 1'b1; sync_restart = 1'b0; ch_en = en;
        set_wr(0, 0, 0);
        step();
        step();
        rst = 1'b0;
        base = cyc;
    endtask

    task automatic test_reset();
        do_reset(3'b111);
        n_chk++; if (tick !== 3'b000) $display("FAIL reset_tick got=%b exp=000", tick); else n_pass++;
        n_chk++; if (cfg_pending !== 3'b000) $display("FAIL reset_pending got=%b exp=000", cfg_pending); else n_pass++;
`ifdef CLK_TICK_GEN_SQUARE_EN
        n_chk++; if (sq !== 3'b000) $display("FAIL reset_sq got=%b exp=000", sq); else n_pass++;
`endif
    endtask

    task automatic test_basic();
        do_reset(3'b111);
        for (int rel = 1; rel <= 12; rel++) begin
            step();
            n_chk++; if (tick[0] !== (rel % 4 == 0)) $display("FAIL basic_tick0 rel=%0d got=%b", rel, tick[0]); else n_pass++;
            n_chk++; if (tick !== e_tick) $display("FAIL basic_tick rel=%0d got=%b exp=%b", rel, tick, e_tick); else n_pass++;
`ifdef CLK_TICK_GEN_SQUARE_EN
            n_chk++; if (sq[0] !== (((rel - 1) % 4) >= 2)) $display("FAIL basic_sq0 rel=%0d got=%b", rel, sq[0]); else n_pass++;
            n_chk++; if (sq !== e_sq) $display("FAIL basic_sq rel=%0d got=%b exp=%b", rel, sq, e_sq); else n_pass++;
`endif
        end
    endtask

    task automatic test_pending();
        do_reset(3'b111);
        for (int rel = 1; rel <= 12; rel++) begin
            if (rel == 2) set_wr(1, 1, 3);
            step();
            set_wr(0, 0, 0);
            n_chk++; if (tick[1] !== (rel == 5 || rel == 8 || rel == 11)) $display("FAIL pend_tick1 rel=%0d got=%b", rel, tick[1]); else n_pass++;
            n_chk++; if (cfg_pending[1] !== (rel >= 2 && rel < 5)) $display("FAIL pend_flag1 rel=%0d got=%b", rel, cfg_pending[1]); else n_pass++;
            n_chk++; if (cfg_pending !== e_pend) $display("FAIL pend_vec rel=%0d got=%b exp=%b", rel, cfg_pending, e_pend); else n_pass++;
        end
    endtask

    task automatic test_wrap_write();
        do_reset(3'b111);
        for (int rel = 1; rel <= 12; rel++) begin
            if (rel == 4) set_wr(1, 0, 6);
            step();
            set_wr(0, 0, 0);
            n_chk++; if (tick[0] !== (rel == 4 || rel == 10)) $display("FAIL wrapwr_tick0 rel=%0d got=%b", rel, tick[0]); else n_pass++;
            n_chk++; if (cfg_pending[0] !== 1'b0) $display("FAIL wrapwr_pend0 rel=%0d got=%b exp=0", rel, cfg_pending[0]); else n_pass++;
        end
    endtask

    task automatic test_enable_gap();
        do_reset(3'b111);
        for (int rel = 1; rel <= 16; rel++) begin
            if (rel == 3) ch_en[2] = 1'b0;
            if (rel == 6) ch_en[2] = 1'b1;
            step();
            n_chk++; if (tick[2] !== (rel == 13)) $display("FAIL engap_tick2 rel=%0d got=%b", rel, tick[2]); else n_pass++;
`ifdef CLK_TICK_GEN_SQUARE_EN
            n_chk++; if (sq !== e_sq) $display("FAIL engap_sq rel=%0d got=%b exp=%b", rel, sq, e_sq); else n_pass++;
`endif
        end
    endtask

    task automatic test_sync_restart();
        do_reset(3'b000);
        set_wr(1, 0, 3); step();
        set_wr(1, 1, 7); step();
        set_wr(0, 0, 0);
        ch_en = 3'b011;
        for (int rel = 1; rel <= 24; rel++) begin
            sync_restart = (rel == 10 || rel == 19);
            if (rel == 18) set_wr(1, 1, 4);
            step();
            sync_restart = 1'b0;
            set_wr(0, 0, 0);
            n_chk++; if (tick[0] !== (rel inside {3, 6, 9, 13, 16, 22})) $display("FAIL sync_tick0 rel=%0d got=%b", rel, tick[0]); else n_pass++;
            n_chk++; if (tick[1] !== (rel inside {7, 17, 23})) $display("FAIL sync_tick1 rel=%0d got=%b", rel, tick[1]); else n_pass++;
            n_chk++; if (cfg_pending[1] !== (rel == 18)) $display("FAIL sync_pend1 rel=%0d got=%b", rel, cfg_pending[1]); else n_pass++;
        end
    endtask

    task automatic test_edges();
        do_reset(3'b100);
        set_wr(1, 0, 0); step();
        set_wr(1, 1, 1); step();
        set_wr(0, 0, 0);
        ch_en = 3'b111;
        base = cyc;
        for (int rel = 1; rel <= 10; rel++) begin
            if (rel >= 2 && rel <= 5) set_wr(1, 3, 2);
            step();
            set_wr(0, 0, 0);
            n_chk++; if (tick[0] !== 1'b0) $display("FAIL div0_tick0 rel=%0d got=%b exp=0", rel, tick[0]); else n_pass++;
            n_chk++; if (tick[1] !== 1'b1) $display("FAIL div1_tick1 rel=%0d got=%b exp=1", rel, tick[1]); else n_pass++;
            n_chk++; if (tick[2] !== e_tick[2]) $display("FAIL badch_tick2 rel=%0d got=%b exp=%b", rel, tick[2], e_tick[2]); else n_pass++;
            n_chk++; if (cfg_pending !== 3'b000) $display("FAIL badch_pend rel=%0d got=%b exp=000", rel, cfg_pending); else n_pass++;
`ifdef CLK_TICK_GEN_SQUARE_EN
            n_chk++; if (sq[1:0] !== 2'b10) $display("FAIL edge_sq rel=%0d got=%b exp=10", rel, sq[1:0]); else n_pass++;
`endif
        end
    endtask

    task automatic test_rst_mid();
        do_reset(3'b111);
        for (int rel = 1; rel <= 7; rel++) begin
            if (rel == 2) set_wr(1, 1, 3);
            step();
            set_wr(0, 0, 0);
        end
        rst = 1'b1;
        set_wr(1, 2, 2);
        step();
        rst = 1'b0;
        set_wr(0, 0, 0);
        base = cyc;
        n_chk++; if (tick !== 3'b000) $display("FAIL rstmid_tick got=%b exp=000", tick); else n_pass++;
        n_chk++; if (cfg_pending !== 3'b000) $display("FAIL rstmid_pend got=%b exp=000", cfg_pending); else n_pass++;
`ifdef CLK_TICK_GEN_SQUARE_EN
        n_chk++; if (sq !== 3'b000) $display("FAIL rstmid_sq got=%b exp=000", sq); else n_pass++;
`endif
        for (int rel = 1; rel <= 6; rel++) begin
            step();
            n_chk++; if (tick[1:0] !== {rel == 5, rel == 4}) $display("FAIL rstmid_after rel=%0d got=%b", rel, tick[1:0]); else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset(3'b111);
        for (int n = 0; n < 3000; n++) begin
            set_wr($urandom_range(3) == 0, $urandom_range(3), $urandom_range(9));
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(15) == 0) ch_en[i] = ~ch_en[i];
            sync_restart = ($urandom_range(39) == 0);
            rst          = ($urandom_range(299) == 0);
            step();
            n_chk++; if (tick !== e_tick) $display("FAIL rnd_tick cyc=%0d got=%b exp=%b", cyc, tick, e_tick); else n_pass++;
            n_chk++; if (cfg_pending !== e_pend) $display("FAIL rnd_pend cyc=%0d got=%b exp=%b", cyc, cfg_pending, e_pend); else n_pass++;
`ifdef CLK_TICK_GEN_SQUARE_EN
            n_chk++; if (sq !== e_sq) $display("FAIL rnd_sq cyc=%0d got=%b exp=%b", cyc, sq, e_sq); else n_pass++;
`endif
        end
        rst = 1'b0; sync_restart = 1'b0; set_wr(0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; sync_restart = 1'b0; ch_en = '0;
        set_wr(0, 0, 0);
        test_reset();
        test_basic();
        test_pending();
        test_wrap_write();
        test_enable_gap();
        test_sync_restart();
        test_edges();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
